// File: rtl/mnist_pkg.sv
// Shared image geometry and transmitter state encoding for the MNIST
// classifier input path.
package mnist_pkg;
   localparam int IMG_W  = 28;
   localparam int IMG_H  = 28;
   localparam int PIX_W  = 8;
   localparam int N_PIX  = IMG_W * IMG_H;
   localparam int ADDR_W = $clog2(N_PIX);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SEND,
      ST_FIN
   } tx_state_t;
endpackage

// File: rtl/pixel_frame_ram.sv
// Single-frame pixel store: one write port, one synchronous read port with
// one cycle of latency. The read register holds when re is low.
module pixel_frame_ram
   import mnist_pkg::*;
#(
   parameter int DEPTH = N_PIX,
   parameter int WIDTH = PIX_W,
   parameter int AW    = ADDR_W
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/pixel_stream_tx.sv
// Buffers one frame and serializes it row-major, MSB first, onto a 1-bit
// valid/ready stream with sof/eof markers.
module pixel_stream_tx #(
   parameter int PIX_W = mnist_pkg::PIX_W
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr_en,
   input  logic [mnist_pkg::ADDR_W-1:0] wr_addr,
   input  logic [PIX_W-1:0]            wr_data,
   input  logic                        start,
   input  logic                        abort,
   input  logic                        ready_in,
   output logic                        data_out,
   output logic                        data_valid,
   output logic                        sof,
   output logic                        eof,
   output logic                        busy,
   output logic                        done,
   output logic                        load_err
);
   import mnist_pkg::*;

   localparam int              BW       = (PIX_W > 1) ? $clog2(PIX_W) : 1;
   localparam logic [BW-1:0]   BIT_TOP  = BW'(PIX_W - 1);
   localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(N_PIX - 1);
   localparam logic [ADDR_W:0] PIX_END  = (ADDR_W + 1)'(N_PIX);

   tx_state_t         state;
   logic [PIX_W-1:0]  shreg, hold, rdata;
   logic              hold_v, rd_v;
   logic [ADDR_W:0]   nxt_rd;
   logic [ADDR_W-1:0] pix_cnt;
   logic [BW-1:0]     bit_cnt;

   logic active, xfer, last_bit, last_xfer, sh_load, hold_free, rd_take, rd_en;
   logic addr_ok, ram_we;

   // Three-deep pixel pipeline: RAM read register -> hold -> shift register.
   // A stage refills whenever it is empty or being drained, so even
   // one-bit pixels stream without bubbles.
   always_comb begin
      active    = (state == ST_FETCH) || (state == ST_SEND);
      xfer      = data_valid && ready_in;
      last_bit  = (bit_cnt == '0);
      last_xfer = xfer && last_bit && (pix_cnt == PIX_LAST);
      sh_load   = active && (!data_valid || (xfer && last_bit && !last_xfer))
                  && (hold_v || rd_v);
      hold_free = !hold_v || sh_load;
      rd_take   = active && rd_v && hold_free;
      rd_en     = active && !abort && (nxt_rd != PIX_END) && (!rd_v || rd_take);
      addr_ok   = ({1'b0, wr_addr} < PIX_END);
      ram_we    = wr_en && (state == ST_IDLE) && addr_ok;
   end

   pixel_frame_ram #(
      .DEPTH (N_PIX),
      .WIDTH (PIX_W),
      .AW    (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_addr),
      .wdata (wr_data),
      .re    (rd_en),
      .raddr (nxt_rd[ADDR_W-1:0]),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         load_err   <= 1'b0;
         shreg      <= '0;
         hold       <= '0;
         hold_v     <= 1'b0;
         rd_v       <= 1'b0;
         nxt_rd     <= '0;
         pix_cnt    <= '0;
         bit_cnt    <= BIT_TOP;
      end else begin
         done     <= 1'b0;
         load_err <= (wr_en && (state != ST_IDLE || !addr_ok))
                     || (start && state != ST_IDLE);
         if (abort && state != ST_IDLE) begin
            state      <= ST_IDLE;
            data_valid <= 1'b0;
            busy       <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start && !abort) begin
                     state   <= ST_FETCH;
                     busy    <= 1'b1;
                     hold_v  <= 1'b0;
                     rd_v    <= 1'b0;
                     nxt_rd  <= '0;
                     pix_cnt <= '0;
                     bit_cnt <= BIT_TOP;
                  end
               end
               ST_FETCH, ST_SEND: begin
                  if (state == ST_FETCH) state <= ST_SEND;
                  if (rd_en) nxt_rd <= nxt_rd + 1'b1;
                  if (rd_en)        rd_v <= 1'b1;
                  else if (rd_take) rd_v <= 1'b0;
                  if (sh_load) shreg <= hold_v ? hold : rdata;
                  // rdata bypasses hold only when hold is empty and the shifter wants it
                  if (rd_take && !(sh_load && !hold_v)) begin
                     hold   <= rdata;
                     hold_v <= 1'b1;
                  end else if (sh_load) begin
                     hold_v <= 1'b0;
                  end
                  if (last_xfer) begin
                     state      <= ST_FIN;
                     data_valid <= 1'b0;
                     done       <= 1'b1;
                  end else begin
                     if (sh_load) data_valid <= 1'b1;
                     if (xfer) begin
                        if (last_bit) begin
                           bit_cnt <= BIT_TOP;
                           pix_cnt <= pix_cnt + 1'b1;
                        end else begin
                           bit_cnt <= bit_cnt - 1'b1;
                        end
                     end
                  end
               end
               ST_FIN: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign data_out = data_valid & shreg[bit_cnt];
   assign sof      = data_valid && (pix_cnt == '0) && (bit_cnt == BIT_TOP);
   assign eof      = data_valid && (pix_cnt == PIX_LAST) && last_bit;
endmodule

// File: tb/tb_pixel_stream_tx.sv
// Directed bench for pixel_stream_tx: an 8-bit instance for frame, stall,
// abort and reset cases, and a 1-bit instance for the binarized stream.
module tb_pixel_stream_tx;
   import mnist_pkg::*;

   localparam int NB8 = N_PIX * 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              wr_en8 = 0, start8 = 0, abort8 = 0, ready8 = 1;
   logic [ADDR_W-1:0] wr_addr8 = '0;
   logic [7:0]        wr_data8 = '0;
   logic              dout8, dv8, sof8, eof8, busy8, done8, lerr8;

   logic              wr_en1 = 0, start1 = 0, abort1 = 0, ready1 = 1;
   logic [ADDR_W-1:0] wr_addr1 = '0;
   logic [0:0]        wr_data1 = '0;
   logic              dout1, dv1, sof1, eof1, busy1, done1, lerr1;

   pixel_stream_tx #(.PIX_W(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8),
      .start(start8), .abort(abort8), .ready_in(ready8), .data_out(dout8),
      .data_valid(dv8), .sof(sof8), .eof(eof8), .busy(busy8), .done(done8), .load_err(lerr8)
   );

   pixel_stream_tx #(.PIX_W(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
      .start(start1), .abort(abort1), .ready_in(ready1), .data_out(dout1),
      .data_valid(dv1), .sof(sof1), .eof(eof1), .busy(busy1), .done(done1), .load_err(lerr1)
   );

   logic sel1 = 1'b0;
   logic dv_s, dout_s, sof_s, eof_s, done_s;
   assign dv_s   = sel1 ? dv1   : dv8;
   assign dout_s = sel1 ? dout1 : dout8;
   assign sof_s  = sel1 ? sof1  : sof8;
   assign eof_s  = sel1 ? eof1  : eof8;
   assign done_s = sel1 ? done1 : done8;

   int   n_chk = 0, n_err = 0;
   logic rx [NB8];
   int   rx_n, rx_first, rx_eof, rx_done, rx_ndone, rx_bad;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] rx_byte(input int k);
      logic [7:0] v = '0;
      for (int b = 0; b < 8; b++) v = {v[6:0], rx[k*8+b]};
      return v;
   endfunction

   function automatic int byte_errs();
      int e = 0;
      for (int k = 0; k < N_PIX; k++) begin
         logic [7:0] ex;
         ex = 8'(k);
         if (rx_byte(k) !== ex) e++;
      end
      return e;
   endfunction

   // Collects a frame starting at the cycle right after the start edge.
   // rx_bad counts protocol faults: marker errors, valid gaps, unstable stalls.
   task automatic rx_frame(input int nbits, input bit toggle);
      logic pv, pr, pd, ps, pe, r;
      rx_n = 0; rx_first = -1; rx_eof = -1; rx_done = -1; rx_ndone = 0; rx_bad = 0;
      pv = 0; pr = 1; pd = 0; ps = 0; pe = 0;
      for (int cyc = 0; cyc < 4 * nbits + 50; cyc++) begin
         r = toggle ? (cyc % 2 == 0) : 1'b1;
         ready8 = r;
         ready1 = r;
         if (pv && !pr && !(dv_s && dout_s === pd && sof_s === ps && eof_s === pe)) rx_bad++;
         if (dv_s) begin
            if (sof_s !== (rx_n == 0)) rx_bad++;
            if (eof_s !== (rx_n == nbits - 1)) rx_bad++;
            if (rx_first < 0) rx_first = cyc;
            if (r) begin
               if (rx_n < NB8) rx[rx_n] = dout_s;
               if (rx_n == nbits - 1) rx_eof = cyc;
               rx_n++;
            end
         end else if (rx_first >= 0 && rx_n < nbits) begin
            rx_bad++;
         end
         if (done_s) begin
            rx_ndone++;
            if (rx_done < 0) rx_done = cyc;
         end
         pv = dv_s; pr = r; pd = dout_s; ps = sof_s; pe = eof_s;
         if (rx_eof >= 0 && cyc > rx_eof + 3) break;
         tick();
      end
      ready8 = 1;
      ready1 = 1;
   endtask

   initial begin
      int n;
      tick();
      chk("rst_valid", dv8, 0);
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_lerr", lerr8, 0);
      chk("rst_sof_eof", {sof8, eof8, dout8}, 0);
      #3 rst_n = 1'b1;
      tick();

      // 1: ramp frame; the final write shares its cycle with start
      for (int i = 0; i < N_PIX; i++) begin
         wr_en8 = 1; wr_addr8 = ADDR_W'(i); wr_data8 = 8'(i);
         if (i == N_PIX - 1) start8 = 1;
         tick();
      end
      wr_en8 = 0; start8 = 0;
      chk("s1_busy", busy8, 1);
      rx_frame(NB8, 0);
      chk("s1_latency", rx_first, 2);
      chk("s1_count", rx_n, NB8);
      chk("s1_span", rx_eof - rx_first, NB8 - 1);
      chk("s1_proto", rx_bad, 0);
      chk("s1_done_dly", rx_done - rx_eof, 1);
      chk("s1_done_cnt", rx_ndone, 1);
      chk("s1_byte0", rx_byte(0), 8'h00);
      chk("s1_byte5", rx_byte(5), 8'h05);
      chk("s1_byte783", rx_byte(N_PIX - 1), 8'h0F);
      chk("s1_bytes", byte_errs(), 0);
      chk("s1_idle", busy8, 0);

      // 2: same frame with ready toggling
      start8 = 1; tick(); start8 = 0;
      rx_frame(NB8, 1);
      chk("s2_count", rx_n, NB8);
      chk("s2_proto", rx_bad, 0);
      chk("s2_bytes", byte_errs(), 0);
      chk("s2_done_cnt", rx_ndone, 1);

      // 3: start and write while busy are refused
      start8 = 1; tick(); start8 = 0;
      n = 0;
      while (!dv8 && n < 10) begin tick(); n++; end
      chk("s3_valid", dv8, 1);
      start8 = 1; tick(); start8 = 0;
      chk("s3_start_err", lerr8, 1);
      tick();
      chk("s3_err_pulse", lerr8, 0);
      wr_en8 = 1; wr_addr8 = '0; wr_data8 = 8'hFF; tick(); wr_en8 = 0;
      chk("s3_wr_err", lerr8, 1);
      abort8 = 1; tick(); abort8 = 0;
      start8 = 1; tick(); start8 = 0;
      rx_frame(NB8, 0);
      chk("s3_pix0", rx_byte(0), 8'h00);
      chk("s3_bytes", byte_errs(), 0);

      // 4: abort after 100 transfers, then IDLE corner cases and restart
      start8 = 1; tick(); start8 = 0;
      n = 0;
      for (int c = 0; c < 200; c++) begin
         if (dv8 && ready8) n++;
         if (n == 100) break;
         tick();
      end
      chk("s4_xfers", n, 100);
      abort8 = 1; tick(); abort8 = 0;
      chk("s4_abort_valid", dv8, 0);
      chk("s4_abort_busy", busy8, 0);
      n = 0;
      for (int c = 0; c < 5; c++) begin tick(); if (done8) n++; end
      chk("s4_no_done", n, 0);
      abort8 = 1; start8 = 1; tick(); abort8 = 0; start8 = 0;
      chk("s4_abort_wins", busy8, 0);
      chk("s4_abort_idle_err", lerr8, 0);
      wr_en8 = 1; wr_addr8 = ADDR_W'(N_PIX); wr_data8 = 8'h77; tick(); wr_en8 = 0;
      chk("s4_addr_err", lerr8, 1);
      wr_en8 = 1; wr_addr8 = '0; wr_data8 = 8'hA5; tick(); wr_en8 = 0;
      chk("s4_wr_ok", lerr8, 0);
      ready8 = 0;
      start8 = 1; tick(); start8 = 0;
      n = 0;
      while (!dv8 && n < 10) begin tick(); n++; end
      chk("s4_restart_sof", sof8, 1);
      chk("s4_restart_bit7", dout8, 1);

      // 5: asynchronous reset while stalled on the first bit
      #2 rst_n = 1'b0;
      #1;
      chk("s5_valid", dv8, 0);
      chk("s5_busy", busy8, 0);
      chk("s5_sof", sof8, 0);
      chk("s5_eof", eof8, 0);
      #3 rst_n = 1'b1;
      ready8 = 1;
      for (int c = 0; c < 5; c++) tick();
      chk("s5_stay_idle", {busy8, dv8}, 0);

      // 6: binarized checkerboard on the 1-bit instance
      for (int r = 0; r < IMG_H; r++)
         for (int c = 0; c < IMG_W; c++) begin
            wr_en1 = 1; wr_addr1 = ADDR_W'(r * IMG_W + c); wr_data1 = 1'((r + c) & 1);
            tick();
         end
      wr_en1 = 0;
      sel1 = 1;
      start1 = 1; tick(); start1 = 0;
      rx_frame(N_PIX, 0);
      chk("s6_count", rx_n, N_PIX);
      chk("s6_span", rx_eof - rx_first, N_PIX - 1);
      chk("s6_proto", rx_bad, 0);
      chk("s6_head", {rx[0], rx[1], rx[2], rx[3]}, 4'b0101);
      chk("s6_row1", rx[IMG_W], 1);
      n = 0;
      for (int r = 0; r < IMG_H; r++)
         for (int c = 0; c < IMG_W; c++)
            if (rx[r * IMG_W + c] !== 1'((r + c) & 1)) n++;
      chk("s6_bits", n, 0);
      chk("s6_done_cnt", rx_ndone, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
